// File: rtl/pc_stage_btb_if.sv
// Fetch-side and resolve-side signals of the PC stage, bundled with directional modports.
// master = the PC stage itself, slave = the surrounding pipeline / memory side.
interface pc_stage_btb_if #(
    parameter int XLEN = 32
);
    logic            stall_fetch;
    logic [XLEN-1:0] pc;
    logic            pc_valid;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;

    logic            ex_resolve_valid;
    logic [XLEN-1:0] ex_pc;
    logic            ex_taken;
    logic [XLEN-1:0] ex_target;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_target;
    logic            ex_is_call;
    logic            ex_is_ret;

    logic            clear_decoding_stage;
    logic            clear_execution_stage;

    modport master (
        input  stall_fetch,
        input  ex_resolve_valid, ex_pc, ex_taken, ex_target,
        input  ex_pred_taken, ex_pred_target, ex_is_call, ex_is_ret,
        output pc, pc_valid, pred_taken, pred_target,
        output clear_decoding_stage, clear_execution_stage
    );

    modport slave (
        output stall_fetch,
        output ex_resolve_valid, ex_pc, ex_taken, ex_target,
        output ex_pred_taken, ex_pred_target, ex_is_call, ex_is_ret,
        input  pc, pc_valid, pred_taken, pred_target,
        input  clear_decoding_stage, clear_execution_stage
    );
endinterface

// File: rtl/pc_stage_btb.sv
// Fetch PC register with a direct-mapped BTB (2-bit saturating counters) and execute-stage redirect.
// Optional return-address stack: define RAS_EN to enable it.
module pc_stage_btb #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              BTB_IDX_BITS = 4,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    pc_stage_btb_if.master bus
);
    localparam int              ENTRIES = 1 << BTB_IDX_BITS;
    localparam int              TAG_W   = XLEN - BTB_IDX_BITS - 2;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0]         pc_q, pc_d;
    logic                    pc_valid_q;

    logic                    btb_valid_q [ENTRIES];
    logic [TAG_W-1:0]        btb_tag_q   [ENTRIES];
    logic [XLEN-1:0]         btb_tgt_q   [ENTRIES];
    logic [1:0]              btb_ctr_q   [ENTRIES];

    logic [BTB_IDX_BITS-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0]        lk_tag, up_tag;
    logic                    lk_hit, up_hit;
    logic [1:0]              up_ctr_cur, up_ctr_d;

    logic [XLEN-1:0]         pc_plus4, ex_pc_plus4, redirect_pc;
    logic                    mispredict;
    logic                    pred_taken;
    logic [XLEN-1:0]         pred_target;

    assign pc_plus4    = pc_q + PC_STEP;
    assign ex_pc_plus4 = bus.ex_pc + PC_STEP;

    assign lk_idx = pc_q[BTB_IDX_BITS+1:2];
    assign lk_tag = pc_q[XLEN-1:BTB_IDX_BITS+2];
    assign lk_hit = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);

    assign up_idx = bus.ex_pc[BTB_IDX_BITS+1:2];
    assign up_tag = bus.ex_pc[XLEN-1:BTB_IDX_BITS+2];
    assign up_hit = btb_valid_q[up_idx] && (btb_tag_q[up_idx] == up_tag);

    assign mispredict = bus.ex_resolve_valid &&
                        ((bus.ex_taken != bus.ex_pred_taken) ||
                         (bus.ex_taken && (bus.ex_target != bus.ex_pred_target)));

    // Taken targets are halfword aligned; bit 0 is always dropped on redirect.
    assign redirect_pc = bus.ex_taken ? {bus.ex_target[XLEN-1:1], 1'b0} : ex_pc_plus4;

    assign up_ctr_cur = btb_ctr_q[up_idx];

    always_comb begin
        up_ctr_d = up_ctr_cur;
        if (bus.ex_taken) begin
            if (up_ctr_cur != 2'b11) begin
                up_ctr_d = up_ctr_cur + 2'b01;
            end
        end else if (up_ctr_cur != 2'b00) begin
            up_ctr_d = up_ctr_cur - 2'b01;
        end
    end

`ifdef RAS_EN
    localparam int                   RAS_PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [RAS_PTR_W-1:0] RAS_LAST  = RAS_PTR_W'(RAS_DEPTH - 1);
    localparam logic [RAS_PTR_W:0]   RAS_FULL  = (RAS_PTR_W + 1)'(RAS_DEPTH);

    logic                 btb_ret_q [ENTRIES];
    logic [XLEN-1:0]      ras_mem_q [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] ras_sp_q, ras_sp_d;
    logic [RAS_PTR_W:0]   ras_cnt_q, ras_cnt_d;
    logic [RAS_PTR_W-1:0] ras_top_idx, ras_wr_idx;
    logic                 ras_wr_en, ras_nonempty, ras_pop, ras_pred;

    function automatic logic [RAS_PTR_W-1:0] ras_inc(input logic [RAS_PTR_W-1:0] p);
        return (p == RAS_LAST) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [RAS_PTR_W-1:0] ras_dec(input logic [RAS_PTR_W-1:0] p);
        return (p == '0) ? RAS_LAST : p - 1'b1;
    endfunction

    // ras_sp_q points at the next free slot; the top of stack sits just below it.
    assign ras_top_idx  = ras_dec(ras_sp_q);
    assign ras_nonempty = (ras_cnt_q != '0);
    assign ras_pop      = bus.ex_is_ret && ras_nonempty;
    assign ras_pred     = lk_hit && btb_ret_q[lk_idx] && ras_nonempty;

    always_comb begin
        ras_sp_d   = ras_sp_q;
        ras_cnt_d  = ras_cnt_q;
        ras_wr_en  = 1'b0;
        ras_wr_idx = ras_sp_q;
        if (bus.ex_resolve_valid) begin
            if (ras_pop && bus.ex_is_call) begin
                // Pop then push collapses to replacing the top entry.
                ras_wr_en  = 1'b1;
                ras_wr_idx = ras_top_idx;
            end else if (ras_pop) begin
                ras_sp_d  = ras_top_idx;
                ras_cnt_d = ras_cnt_q - 1'b1;
            end else if (bus.ex_is_call) begin
                ras_wr_en  = 1'b1;
                ras_wr_idx = ras_sp_q;
                ras_sp_d   = ras_inc(ras_sp_q);
                if (ras_cnt_q != RAS_FULL) begin
                    ras_cnt_d = ras_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ras_sp_q  <= '0;
            ras_cnt_q <= '0;
        end else begin
            ras_sp_q  <= ras_sp_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (ras_wr_en && rst_n_i) begin
            ras_mem_q[ras_wr_idx] <= ex_pc_plus4;
        end
    end

    assign pred_taken  = pc_valid_q && lk_hit && (btb_ctr_q[lk_idx][1] || ras_pred);
    assign pred_target = ras_pred ? ras_mem_q[ras_top_idx] :
                         (lk_hit ? btb_tgt_q[lk_idx] : pc_plus4);
`else
    logic unused_ras_inputs;
    assign unused_ras_inputs = bus.ex_is_call ^ bus.ex_is_ret ^ (RAS_DEPTH != 0);

    assign pred_taken  = pc_valid_q && lk_hit && btb_ctr_q[lk_idx][1];
    assign pred_target = lk_hit ? btb_tgt_q[lk_idx] : pc_plus4;
`endif

    // The reset vector is itself fetched: PC holds until PC_VALID has risen.
    always_comb begin
        pc_d = pc_q;
        if (mispredict) begin
            pc_d = redirect_pc;
        end else if (bus.stall_fetch || !pc_valid_q) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end else begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_q       <= RESET_VECTOR;
            pc_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_valid_q <= 1'b1;
        end
    end

    // Training is independent of stalls; lookups this cycle see pre-update contents.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid_q[i] <= 1'b0;
                btb_tag_q[i]   <= '0;
                btb_tgt_q[i]   <= '0;
                btb_ctr_q[i]   <= 2'b01;
`ifdef RAS_EN
                btb_ret_q[i]   <= 1'b0;
`endif
            end
        end else if (bus.ex_resolve_valid) begin
            if (up_hit) begin
                btb_ctr_q[up_idx] <= up_ctr_d;
                if (bus.ex_taken) begin
                    btb_tgt_q[up_idx] <= bus.ex_target;
                end
`ifdef RAS_EN
                btb_ret_q[up_idx] <= bus.ex_is_ret;
`endif
            end else if (bus.ex_taken) begin
                btb_valid_q[up_idx] <= 1'b1;
                btb_tag_q[up_idx]   <= up_tag;
                btb_tgt_q[up_idx]   <= bus.ex_target;
                btb_ctr_q[up_idx]   <= 2'b10;
`ifdef RAS_EN
                btb_ret_q[up_idx]   <= bus.ex_is_ret;
`endif
            end
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_valid    = pc_valid_q;
    assign bus.pred_taken  = pred_taken;
    assign bus.pred_target = pred_target;

    assign bus.clear_decoding_stage  = mispredict && rst_n_i;
    assign bus.clear_execution_stage = mispredict && rst_n_i;
endmodule

// File: tb/tb_pc_stage_btb.sv
// Scoreboard bench for pc_stage_btb: the stimulus pushes hand-computed per-cycle expectations,
// a monitor pops and compares them on the falling edge.
module tb_pc_stage_btb;
    logic clk;
    logic rst_n;

    pc_stage_btb_if #(.XLEN(32)) bus_if ();

    pc_stage_btb #(
        .XLEN        (32),
        .RESET_VECTOR(32'h0000_0100),
        .BTB_IDX_BITS(4),
        .RAS_DEPTH   (4)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus_if)
    );

    typedef struct {
        int          step;
        logic [31:0] pc;
        logic        pc_valid;
        logic        pred_taken;
        logic [31:0] pred_target;
        logic        clr;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   step_no = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s step %0d: got %h want %h", name, step, act, req);
        end
    endtask

    task automatic expect_out(input logic [31:0] pc, input logic v, input logic pt,
                              input logic [31:0] tgt, input logic clr);
        exp_q.push_back('{step: step_no, pc: pc, pc_valid: v, pred_taken: pt,
                          pred_target: tgt, clr: clr});
        step_no++;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
        bus_if.ex_resolve_valid = 1'b1;
        bus_if.ex_pc            = pc;
        bus_if.ex_taken         = tk;
        bus_if.ex_target        = tgt;
        bus_if.ex_pred_taken    = ptk;
        bus_if.ex_pred_target   = ptgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus_if.ex_resolve_valid = 1'b0;
    endtask

    // Monitor: compares whatever expectation is pending for the current cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("txn %0d: pc=%h valid=%b pt=%b tgt=%h clr=%b/%b", e.step,
                         bus_if.pc, bus_if.pc_valid, bus_if.pred_taken, bus_if.pred_target,
                         bus_if.clear_decoding_stage, bus_if.clear_execution_stage);
                chk("pc",          e.step, bus_if.pc,                           e.pc);
                chk("pc_valid",    e.step, 32'(bus_if.pc_valid),                32'(e.pc_valid));
                chk("pred_taken",  e.step, 32'(bus_if.pred_taken),              32'(e.pred_taken));
                chk("pred_target", e.step, bus_if.pred_target,                  e.pred_target);
                chk("clear_dec",   e.step, 32'(bus_if.clear_decoding_stage),    32'(e.clr));
                chk("clear_exe",   e.step, 32'(bus_if.clear_execution_stage),   32'(e.clr));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n                  = 1'b0;
        bus_if.stall_fetch     = 1'b0;
        bus_if.ex_resolve_valid = 1'b0;
        bus_if.ex_pc           = '0;
        bus_if.ex_taken        = 1'b0;
        bus_if.ex_target       = '0;
        bus_if.ex_pred_taken   = 1'b0;
        bus_if.ex_pred_target  = '0;
        bus_if.ex_is_call      = 1'b0;
        bus_if.ex_is_ret       = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        // Reset: a would-be mispredict must not raise the clears.
        resolve(32'h108, 1'b1, 32'h200, 1'b0, 32'h10C);
        expect_out(32'h100, 1'b0, 1'b0, 32'h104, 1'b0);
        tick(); rst_n = 1'b1;
        expect_out(32'h100, 1'b0, 1'b0, 32'h104, 1'b0);
        tick(); expect_out(32'h100, 1'b1, 1'b0, 32'h104, 1'b0);
        tick(); expect_out(32'h104, 1'b1, 1'b0, 32'h108, 1'b0);
        // Branch at 0x108 taken to 0x200, predicted not taken.
        tick(); resolve(32'h108, 1'b1, 32'h200, 1'b0, 32'h10C);
        expect_out(32'h108, 1'b1, 1'b0, 32'h10C, 1'b1);
        tick(); expect_out(32'h200, 1'b1, 1'b0, 32'h204, 1'b0);
        // Not-taken mispredict at 0x104 steers fetch back to 0x108.
        tick(); resolve(32'h104, 1'b0, 32'h0, 1'b1, 32'h108);
        expect_out(32'h204, 1'b1, 1'b0, 32'h208, 1'b1);
        tick(); expect_out(32'h108, 1'b1, 1'b1, 32'h200, 1'b0);
        // Two not-taken resolves: ctr 10 -> 01 -> 00, both redirect to 0x10C.
        tick(); resolve(32'h108, 1'b0, 32'h0, 1'b1, 32'h200);
        expect_out(32'h200, 1'b1, 1'b0, 32'h204, 1'b1);
        tick(); resolve(32'h108, 1'b0, 32'h0, 1'b1, 32'h200);
        expect_out(32'h10C, 1'b1, 1'b0, 32'h110, 1'b1);
        tick(); resolve(32'h104, 1'b0, 32'h0, 1'b1, 32'h108);
        expect_out(32'h10C, 1'b1, 1'b0, 32'h110, 1'b1);
        // Hit with ctr 00: not taken, target still the entry's; correct not-taken keeps ctr at 00.
        tick(); resolve(32'h108, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_out(32'h108, 1'b1, 1'b0, 32'h200, 1'b0);
        tick(); resolve(32'h104, 1'b0, 32'h0, 1'b1, 32'h108);
        expect_out(32'h10C, 1'b1, 1'b0, 32'h110, 1'b1);
        tick(); resolve(32'h100, 1'b0, 32'h0, 1'b1, 32'h104);
        expect_out(32'h108, 1'b1, 1'b0, 32'h200, 1'b1);
        // Stall three cycles at 0x104, target-mismatch mispredict to 0x300 in the second.
        tick(); bus_if.stall_fetch = 1'b1;
        expect_out(32'h104, 1'b1, 1'b0, 32'h108, 1'b0);
        tick(); resolve(32'h2F0, 1'b1, 32'h300, 1'b1, 32'h2F4);
        expect_out(32'h104, 1'b1, 1'b0, 32'h108, 1'b1);
        tick(); expect_out(32'h300, 1'b1, 1'b0, 32'h304, 1'b0);
        tick(); bus_if.stall_fetch = 1'b0;
        expect_out(32'h300, 1'b1, 1'b0, 32'h304, 1'b0);
        // Odd target has bit 0 cleared; then PC+4 wraps past the top of memory.
        tick(); resolve(32'h10, 1'b1, 32'hFFFF_FFFD, 1'b0, 32'h0);
        expect_out(32'h304, 1'b1, 1'b0, 32'h308, 1'b1);
        tick(); expect_out(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0, 1'b0);
        tick(); resolve(32'h108, 1'b1, 32'h200, 1'b1, 32'h200);
        expect_out(32'h0, 1'b1, 1'b0, 32'h4, 1'b0);
        // Asynchronous reset mid-run: state and BTB cleared, pending resolve dropped.
        tick(); rst_n = 1'b0; resolve(32'h108, 1'b1, 32'h200, 1'b0, 32'h10C);
        expect_out(32'h100, 1'b0, 1'b0, 32'h104, 1'b0);
        tick(); rst_n = 1'b1;
        expect_out(32'h100, 1'b0, 1'b0, 32'h104, 1'b0);
        tick(); expect_out(32'h100, 1'b1, 1'b0, 32'h104, 1'b0);
        tick(); expect_out(32'h104, 1'b1, 1'b0, 32'h108, 1'b0);
        tick(); expect_out(32'h108, 1'b1, 1'b0, 32'h10C, 1'b0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pc_stage_btb.md
Name: pc_stage_btb

Overview:
Parametrised successor to the fetch program-counter stage. Holds the architectural fetch PC and selects next PC from pc+4, a direct-mapped BTB with 2-bit saturating counters, or an execute-stage redirect. Generates pipeline flush strobes on mispredict and trains the BTB from resolved control-flow instructions. Sits between the instruction-memory interface and the decode stage.

Parameters:
XLEN, 32, PC/data width in bits
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
BTB_IDX_BITS, 4, log2 of BTB entries (16 entries default)
RAS_DEPTH, 4, return-stack entries (used only with RAS_EN)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
STALL_FETCH  in  1  hold PC (decode/memory not ready)
PC  out  XLEN  current fetch PC
PC_VALID  out  1  PC is a valid fetch address
PRED_TAKEN  out  1  prediction for PC, travels with instruction
PRED_TARGET  out  XLEN  predicted target for PC
EX_RESOLVE_VALID  in  1  execute stage resolves a control-flow instruction this cycle
EX_PC  in  XLEN  PC of the resolving instruction
EX_TAKEN  in  1  actual direction
EX_TARGET  in  XLEN  actual target (JAL/JALR/branch)
EX_PRED_TAKEN  in  1  prediction carried with that instruction
EX_PRED_TARGET  in  XLEN  predicted target carried with that instruction
EX_IS_CALL  in  1  instruction is a call (JAL/JALR with rd=x1/x5)
EX_IS_RET  in  1  instruction is a return (JALR rs1=x1/x5, rd=x0)
CLEAR_DECODING_STAGE  out  1  flush decode register
CLEAR_EXECUTION_STAGE  out  1  flush execute register

Behaviour:
- Reset (RST_N=0, async): PC=RESET_VECTOR, PC_VALID=0, all BTB valid bits 0, counters 2'b01, RAS empty; CLEAR_* outputs are 0 while RST_N=0.
- PC_VALID rises on the first rising edge after RST_N deasserts and stays 1.
- Mispredict (combinational) = EX_RESOLVE_VALID & ((EX_TAKEN != EX_PRED_TAKEN) | (EX_TAKEN & EX_TARGET != EX_PRED_TARGET)).
- Redirect PC = EX_TAKEN ? {EX_TARGET[XLEN-1:1],1'b0} : EX_PC+4.
- Next-PC priority at each edge: mispredict -> redirect PC; else STALL_FETCH -> hold; else PRED_TAKEN -> PRED_TARGET; else PC+4. Mispredict overrides stall.
- CLEAR_DECODING_STAGE = CLEAR_EXECUTION_STAGE = mispredict, same cycle, combinational; not asserted on correct prediction.
- All adds are modulo 2^XLEN (PC+4 at max address wraps to 0).
- BTB: index = PC[BTB_IDX_BITS+1:2], tag = PC[XLEN-1:BTB_IDX_BITS+2]. Entry = {valid, tag, target, ctr[1:0], is_ret}.
- Lookup combinational on PC: hit = valid & tag match; PRED_TAKEN = hit & ctr[1] & PC_VALID; PRED_TARGET = entry target on hit, else PC+4.
- Update on EX_RESOLVE_VALID rising edge, indexed by EX_PC: hit -> ctr saturating +1 if taken / -1 if not (bounds 00,11), target written when taken, is_ret<=EX_IS_RET; miss & taken -> allocate (overwrite), ctr=2'b10, target=EX_TARGET; miss & not taken -> no change.
- Same-index lookup and update in one cycle: lookup sees pre-update contents.
- BTB updates happen regardless of STALL_FETCH.
- Reset mid-operation: all state returns to reset values immediately; pending resolve is discarded.

Optional Feature:
RAS_EN: when defined, adds a RAS_DEPTH-entry return address stack updated at resolve: EX_IS_CALL pushes EX_PC+4; EX_IS_RET pops; call+ret in one cycle = pop then push. Full push overwrites oldest (circular); pop on empty ignored. On BTB hit with is_ret=1 and RAS non-empty, PRED_TARGET = RAS top and PRED_TAKEN=1. When undefined: no stack, is_ret ignored, BTB target used for all hits.

Test Plan:
- Reset RESET_VECTOR=32'h100, release, no resolves -> PC sequence 0x100,0x104,0x108; PC_VALID 0 then 1; PRED_TAKEN=0.
- Branch at 0x108 resolves taken to 0x200 with EX_PRED_TAKEN=0 -> CLEAR_* high that cycle, next PC=0x200; BTB entry alloc ctr=10; next fetch of 0x108 gives PRED_TAKEN=1, PRED_TARGET=0x200.
- Same branch resolved not-taken twice -> ctr 10->01->00; second-mispredict redirect PC=0x10C; subsequent fetch of 0x108 predicts not taken.
- STALL_FETCH=1 for 3 cycles at PC=0x104 with simultaneous mispredict to 0x300 in cycle 2 -> PC holds 0x104, then 0x300 next edge.
- PC=32'hFFFF_FFFC, no prediction -> next PC=0x0.
- (RAS_EN) call at 0x400 resolved, ret at 0x800 trained -> fetch of 0x800 predicts 0x404; five calls with RAS_DEPTH=4 -> fifth pop returns oldest-overwritten-correctly order, empty pop ignored.
